// File: rtl/charger_pkg.sv
// -----------------------------------------------------------------------------
// charger_pkg
// Shared definitions for the charger amount/timer blocks:
//   state_t     - controller states IDLE / ENTRY / TIMING
//   KEY_CLEAR   - keypad code that clears the current entry
//   KEY_CANCEL  - keypad code that cancels entry or a running charge
//   is_digit()  - true for keypad codes 0..9
// -----------------------------------------------------------------------------
package charger_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        TIMING = 2'd2
    } state_t;

    localparam logic [3:0] KEY_CLEAR  = 4'hA;
    localparam logic [3:0] KEY_CANCEL = 4'hC;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Divides clk into a one-cycle tick enable, one tick every TICK_DIV cycles.
// The first tick after clr (or reset) comes exactly TICK_DIV cycles later.
// Ports:
//   clk   - system clock
//   rst_n - synchronous reset, active-low
//   clr   - synchronous restart of the divider
//   tick  - high for one cycle when the counter reaches TICK_DIV-1
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(TICK_DIV - 1));

    // NOTE: registered state is updated with non-blocking assignments so every
    // flop samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/amount_manager_param.sv
// -----------------------------------------------------------------------------
// amount_manager_param
// Collects a multi-digit amount from keypad strobes, saturates it at
// MAX_AMOUNT, converts it to charge time and counts that time down on an
// internal tick enable (single clock domain).
// Ports:
//   clk            - system clock
//   rst_n          - synchronous reset, active-low
//   key_valid      - one-cycle strobe qualifying key_value
//   key_value      - 0-9 digit, KEY_CLEAR, KEY_CANCEL; other codes ignored
//   start          - begin charging (level or pulse)
//   all_money      - accepted amount
//   remaining_time - remaining time units (0 outside TIMING)
//   timing         - relay enable, high while counting down
//   done           - one-cycle pulse on natural expiry only
// -----------------------------------------------------------------------------
module amount_manager_param
    import charger_pkg::*;
#(
    parameter int N_DIGITS      = 2,
    parameter int MAX_AMOUNT    = 20,
    parameter int TIME_PER_UNIT = 2,
    parameter int TICK_DIV      = 50000000,
    parameter int ENTRY_TIMEOUT = 30,
    parameter int MONEY_W       = $clog2(MAX_AMOUNT + 1),
    parameter int TIME_W        = $clog2(MAX_AMOUNT * TIME_PER_UNIT + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_valid,
    input  logic [3:0]         key_value,
    input  logic               start,
    output logic [MONEY_W-1:0] all_money,
    output logic [TIME_W-1:0]  remaining_time,
    output logic               timing,
    output logic               done
);

    localparam int DIG_W  = $clog2(N_DIGITS + 1);
    localparam int IDLE_W = (ENTRY_TIMEOUT > 0) ? $clog2(ENTRY_TIMEOUT + 1) : 1;
    // Four extra bits hold all_money*10+digit for any all_money without wrap.
    localparam int ACC_W  = MONEY_W + 4;

    state_t             state;
    logic [DIG_W-1:0]   digits;
    logic [IDLE_W-1:0]  idle_ticks;
    logic               tick;
    logic               tick_clr;

    logic               key_digit;
    logic               key_cancel;
    logic               key_abort;
    logic               digit_ok;
    logic               timeout_hit;
    logic [ACC_W-1:0]   acc;
    logic [MONEY_W-1:0] money_next;

    assign key_digit  = key_valid && is_digit(key_value);
    assign key_cancel = key_valid && (key_value == KEY_CANCEL);
    assign key_abort  = key_cancel || (key_valid && (key_value == KEY_CLEAR));
    // digits is 0 in IDLE, so the first digit always passes this check.
    assign digit_ok   = key_digit && (digits < DIG_W'(N_DIGITS));

    // all_money is 0 in IDLE, so the same accumulate covers the first digit.
    assign acc        = ACC_W'(all_money) * ACC_W'(10) + ACC_W'(key_value);
    assign money_next = (acc > ACC_W'(MAX_AMOUNT)) ? MONEY_W'(MAX_AMOUNT)
                                                   : acc[MONEY_W-1:0];

    assign timeout_hit = (ENTRY_TIMEOUT != 0) && tick &&
                         (idle_ticks == IDLE_W'(ENTRY_TIMEOUT - 1));

    // Divider restarts whenever the FSM changes state or accepts a key, and is
    // held at zero in IDLE.
    always_comb begin
        // NOTE: default first so every path assigns tick_clr and no latch forms.
        tick_clr = 1'b1;
        case (state)
            IDLE:    tick_clr = 1'b1;
            ENTRY:   tick_clr = start || digit_ok || key_abort || timeout_hit;
            TIMING:  tick_clr = key_cancel;
            default: tick_clr = 1'b1;
        endcase
    end

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tick_clr),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            all_money      <= '0;
            remaining_time <= '0;
            timing         <= 1'b0;
            done           <= 1'b0;
            digits         <= '0;
            idle_ticks     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_digit) begin
                        state      <= ENTRY;
                        all_money  <= money_next;
                        digits     <= DIG_W'(1);
                        idle_ticks <= '0;
                    end
                end

                ENTRY: begin
                    // start outranks any key strobe in the same cycle.
                    if (start) begin
                        digits     <= '0;
                        idle_ticks <= '0;
                        if (all_money != '0) begin
                            state          <= TIMING;
                            remaining_time <= TIME_W'(all_money * TIME_PER_UNIT);
                            timing         <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (key_abort) begin
                        state      <= IDLE;
                        all_money  <= '0;
                        digits     <= '0;
                        idle_ticks <= '0;
                    end else if (digit_ok) begin
                        all_money  <= money_next;
                        digits     <= digits + 1'b1;
                        idle_ticks <= '0;
                    end else if (timeout_hit) begin
                        state      <= IDLE;
                        all_money  <= '0;
                        digits     <= '0;
                        idle_ticks <= '0;
                    end else if (tick) begin
                        idle_ticks <= idle_ticks + 1'b1;
                    end
                end

                TIMING: begin
                    // Cancel outranks the final tick, so it never yields done.
                    if (key_cancel) begin
                        state          <= IDLE;
                        all_money      <= '0;
                        remaining_time <= '0;
                        timing         <= 1'b0;
                    end else if (tick) begin
                        if (remaining_time == TIME_W'(1)) begin
                            state          <= IDLE;
                            all_money      <= '0;
                            remaining_time <= '0;
                            timing         <= 1'b0;
                            done           <= 1'b1;
                        end else begin
                            remaining_time <= remaining_time - 1'b1;
                        end
                    end
                end

                default: begin
                    state          <= IDLE;
                    all_money      <= '0;
                    remaining_time <= '0;
                    timing         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_amount_manager_param.sv
// -----------------------------------------------------------------------------
// tb_amount_manager_param
// Directed stimulus pushes hand-computed expectations, tagged with the clock
// edge they refer to, into a scoreboard queue; a negedge monitor pops and
// compares them against the DUT outputs, and flags any done pulse that no
// expectation asked for.
// -----------------------------------------------------------------------------
module tb_amount_manager_param;

    localparam int N_DIGITS      = 2;
    localparam int MAX_AMOUNT    = 20;
    localparam int TIME_PER_UNIT = 2;
    localparam int TICK_DIV      = 4;
    localparam int ENTRY_TIMEOUT = 3;
    localparam int MONEY_W       = $clog2(MAX_AMOUNT + 1);
    localparam int TIME_W        = $clog2(MAX_AMOUNT * TIME_PER_UNIT + 1);

    logic               clk = 1'b0;
    logic               rst_n;
    logic               key_valid;
    logic [3:0]         key_value;
    logic               start;
    logic [MONEY_W-1:0] all_money;
    logic [TIME_W-1:0]  remaining_time;
    logic               timing;
    logic               done;

    amount_manager_param #(
        .N_DIGITS      (N_DIGITS),
        .MAX_AMOUNT    (MAX_AMOUNT),
        .TIME_PER_UNIT (TIME_PER_UNIT),
        .TICK_DIV      (TICK_DIV),
        .ENTRY_TIMEOUT (ENTRY_TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .key_valid      (key_valid),
        .key_value      (key_value),
        .start          (start),
        .all_money      (all_money),
        .remaining_time (remaining_time),
        .timing         (timing),
        .done           (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    at;
        string name;
        int    money;
        int    rtime;
        bit    tmg;
        bit    dn;
    } exp_t;

    exp_t sb_q[$];
    int   cyc      = 0;
    int   edge_n   = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   done_exp_now;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int am, input int ar, input bit at, input bit ad,
                         input int em, input int er, input bit et, input bit ed);
        n_checks++;
        if (am == em && ar == er && at == et && ad == ed) begin
            n_pass++;
        end else begin
            $display("FAIL %s @edge %0d: got money=%0d time=%0d timing=%0b done=%0b, expected money=%0d time=%0d timing=%0b done=%0b",
                     name, cyc, am, ar, at, ad, em, er, et, ed);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s @edge %0d: got %0d, expected %0d", name, cyc, act, req);
    endtask

    // One input cycle; edge_n is the edge that will sample these inputs.
    task automatic drive(input bit kv, input logic [3:0] kval, input bit st, input bit rn);
        @(negedge clk);
        key_valid = kv;
        key_value = kval;
        start     = st;
        rst_n     = rn;
        edge_n    = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 4'h0, 1'b0, 1'b1);
    endtask

    task automatic expect_at(input int at, input string name, input int m, input int r,
                             input bit t, input bit d);
        exp_t e;
        e.at = at; e.name = name; e.money = m; e.rtime = r; e.tmg = t; e.dn = d;
        sb_q.push_back(e);
    endtask

    // Monitor: state after edge `cyc` is stable at this negedge.
    always @(negedge clk) begin
        done_exp_now = 1'b0;
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].at == cyc) begin
                if (sb_q[i].dn) done_exp_now = 1'b1;
                check(sb_q[i].name, int'(all_money), int'(remaining_time), timing, done,
                      sb_q[i].money, sb_q[i].rtime, sb_q[i].tmg, sb_q[i].dn);
                sb_q.delete(i);
            end
        end
        if (done === 1'b1) check_int("done_pulse_expected", int'(done), int'(done_exp_now));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        rst_n = 1'b0; key_valid = 1'b0; key_value = 4'h0; start = 1'b0;

        // Reset
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        expect_at(edge_n, "reset", 0, 0, 1'b0, 1'b0);
        idle(1);
        expect_at(edge_n, "idle_after_reset", 0, 0, 1'b0, 1'b0);

        // 1, 5, start -> 15 units, 30 time units, natural expiry
        drive(1'b1, 4'd1, 1'b0, 1'b1);
        expect_at(edge_n, "t1_key1", 1, 0, 1'b0, 1'b0);
        drive(1'b1, 4'd5, 1'b0, 1'b1);
        expect_at(edge_n, "t1_key5", 15, 0, 1'b0, 1'b0);
        drive(1'b0, 4'h0, 1'b1, 1'b1);
        s = edge_n;
        expect_at(s,       "t1_start",      15, 30, 1'b1, 1'b0);
        expect_at(s + 3,   "t1_pre_tick",   15, 30, 1'b1, 1'b0);
        expect_at(s + 4,   "t1_tick1",      15, 29, 1'b1, 1'b0);
        expect_at(s + 116, "t1_last_unit",  15, 1,  1'b1, 1'b0);
        expect_at(s + 119, "t1_before_end", 15, 1,  1'b1, 1'b0);
        expect_at(s + 120, "t1_done",       0,  0,  1'b0, 1'b1);
        expect_at(s + 121, "t1_after_done", 0,  0,  1'b0, 1'b0);
        idle(122);

        // 3, 7 (saturates), 1 (ignored), start, cancel
        drive(1'b1, 4'd3, 1'b0, 1'b1);
        expect_at(edge_n, "t2_key3", 3, 0, 1'b0, 1'b0);
        drive(1'b1, 4'd7, 1'b0, 1'b1);
        expect_at(edge_n, "t2_key7_sat", 20, 0, 1'b0, 1'b0);
        drive(1'b1, 4'd1, 1'b0, 1'b1);
        expect_at(edge_n, "t2_key1_ignored", 20, 0, 1'b0, 1'b0);
        drive(1'b0, 4'h0, 1'b1, 1'b1);
        expect_at(edge_n, "t2_start", 20, 40, 1'b1, 1'b0);
        drive(1'b1, 4'hC, 1'b0, 1'b1);
        expect_at(edge_n, "t2_cancel", 0, 0, 1'b0, 1'b0);
        idle(2);

        // 0, start -> back to IDLE; then 1, 2 proves a fresh entry; clear
        drive(1'b1, 4'd0, 1'b0, 1'b1);
        expect_at(edge_n, "t3_key0", 0, 0, 1'b0, 1'b0);
        drive(1'b0, 4'h0, 1'b1, 1'b1);
        expect_at(edge_n, "t3_start_zero", 0, 0, 1'b0, 1'b0);
        drive(1'b0, 4'h0, 1'b1, 1'b1);
        expect_at(edge_n, "t3_start_in_idle", 0, 0, 1'b0, 1'b0);
        drive(1'b1, 4'd1, 1'b0, 1'b1);
        expect_at(edge_n, "t3_key1", 1, 0, 1'b0, 1'b0);
        drive(1'b1, 4'd2, 1'b0, 1'b1);
        expect_at(edge_n, "t3_key2", 12, 0, 1'b0, 1'b0);
        drive(1'b1, 4'hA, 1'b0, 1'b1);
        expect_at(edge_n, "t3_clear", 0, 0, 1'b0, 1'b0);
        idle(2);

        // 5, start, cancel at remaining_time=7
        drive(1'b1, 4'd5, 1'b0, 1'b1);
        expect_at(edge_n, "t4_key5", 5, 0, 1'b0, 1'b0);
        drive(1'b0, 4'h0, 1'b1, 1'b1);
        s = edge_n;
        expect_at(s,      "t4_start", 5, 10, 1'b1, 1'b0);
        expect_at(s + 12, "t4_rt7",   5, 7,  1'b1, 1'b0);
        expect_at(s + 13, "t4_rt7b",  5, 7,  1'b1, 1'b0);
        idle(13);
        drive(1'b1, 4'hC, 1'b0, 1'b1);
        expect_at(s + 14, "t4_cancel",  0, 0, 1'b0, 1'b0);
        expect_at(s + 16, "t4_no_done", 0, 0, 1'b0, 1'b0);
        idle(4);

        // 1, start, cancel on the final tick
        drive(1'b1, 4'd1, 1'b0, 1'b1);
        expect_at(edge_n, "t4b_key1", 1, 0, 1'b0, 1'b0);
        drive(1'b0, 4'h0, 1'b1, 1'b1);
        s = edge_n;
        expect_at(s,     "t4b_start", 1, 2, 1'b1, 1'b0);
        expect_at(s + 4, "t4b_rt1",   1, 1, 1'b1, 1'b0);
        expect_at(s + 7, "t4b_rt1b",  1, 1, 1'b1, 1'b0);
        idle(7);
        drive(1'b1, 4'hC, 1'b0, 1'b1);
        expect_at(s + 8, "t4b_cancel_final", 0, 0, 1'b0, 1'b0);
        expect_at(s + 9, "t4b_after",        0, 0, 1'b0, 1'b0);
        idle(3);

        // 4 then nothing -> timeout 12 cycles later
        drive(1'b1, 4'd4, 1'b0, 1'b1);
        s = edge_n;
        expect_at(s,      "t5_key4",        4, 0, 1'b0, 1'b0);
        expect_at(s + 11, "t5_pre_timeout", 4, 0, 1'b0, 1'b0);
        expect_at(s + 12, "t5_timeout",     0, 0, 1'b0, 1'b0);
        idle(13);

        // 4 then clear
        drive(1'b1, 4'd4, 1'b0, 1'b1);
        expect_at(edge_n, "t5b_key4", 4, 0, 1'b0, 1'b0);
        drive(1'b1, 4'hA, 1'b0, 1'b1);
        expect_at(edge_n, "t5b_clear", 0, 0, 1'b0, 1'b0);
        idle(2);

        // 2, then start + key 9 together, then reset mid-TIMING
        drive(1'b1, 4'd2, 1'b0, 1'b1);
        expect_at(edge_n, "t6_key2", 2, 0, 1'b0, 1'b0);
        drive(1'b1, 4'd9, 1'b1, 1'b1);
        s = edge_n;
        expect_at(s,     "t6_start_wins", 2, 4, 1'b1, 1'b0);
        expect_at(s + 1, "t6_timing",     2, 4, 1'b1, 1'b0);
        idle(1);
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        expect_at(s + 2, "t6_reset",       0, 0, 1'b0, 1'b0);
        expect_at(s + 3, "t6_after_reset", 0, 0, 1'b0, 1'b0);
        expect_at(s + 6, "t6_stays_idle",  0, 0, 1'b0, 1'b0);
        idle(6);

        idle(2);
        check_int("pending_expectations", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/amount_manager_param.md
Name: amount_manager_param

Overview:
Parametrised successor of the charger's amount/timer block. It accepts a multi-digit amount from the keypad, saturates it at a configurable maximum, and converts it to charge time. It then counts that time down on an internal tick enable, with no derived clock. It sits between the keypad decoder (debounced, single-cycle key strobes) and the display/relay drivers. Added over the previous generation: explicit key strobe, so digit 0 is legal; clear and cancel keys; entry timeout; a done pulse; and single-clock-domain timing.

Parameters:
N_DIGITS, 2, maximum digits accepted per entry
MAX_AMOUNT, 20, saturation value of the entered amount (>=1)
TIME_PER_UNIT, 2, time units granted per money unit
TICK_DIV, 50000000, clk cycles per time tick (>=2)
ENTRY_TIMEOUT, 30, ticks without a key in ENTRY before abandon; 0 disables the timeout
MONEY_W, $clog2(MAX_AMOUNT+1), derived width of the amount
TIME_W, $clog2(MAX_AMOUNT*TIME_PER_UNIT+1), derived width of the remaining time

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
key_valid  in  1  one-cycle strobe: key_value is valid this cycle
key_value  in  4  0-9 digit; 4'hA clear; 4'hC cancel; other codes ignored
start  in  1  level or pulse; sampled every cycle
all_money  out  MONEY_W  accepted amount, binary
remaining_time  out  TIME_W  remaining time units, binary
timing  out  1  high while in TIMING (charger relay enable)
done  out  1  one-cycle pulse on natural expiry only

Behaviour:
- All outputs and state are registered. Reset is synchronous and active-low: on the edge where rst_n=0, state=IDLE, all_money=0, remaining_time=0, timing=0, done=0, tick counter=0, digit count=0. Reset mid-operation aborts silently; no done pulse.
- States: IDLE, ENTRY, TIMING.
- IDLE:
  - all_money=0 and remaining_time=0.
  - Digit key -> ENTRY, all_money=min(digit,MAX_AMOUNT), digits=1.
  - start, clear and cancel are ignored.
- ENTRY:
  - Digit key with digits<N_DIGITS: all_money=min(all_money*10+digit, MAX_AMOUNT), digits+1. The product is computed at MONEY_W+4 bits so there is no wrap.
  - Digit key with digits==N_DIGITS: ignored.
  - Clear or cancel key -> IDLE, all_money=0.
  - start with all_money>0 -> TIMING. On the same edge: remaining_time=all_money*TIME_PER_UNIT, timing=1, tick counter=0.
  - start with all_money==0 -> IDLE.
  - start and key_valid in the same cycle: start wins and the key is discarded.
  - Timeout: idle-tick count reaching ENTRY_TIMEOUT -> IDLE, all_money=0. The count restarts on every accepted key.
- TIMING:
  - Keys other than cancel are ignored, and start is ignored.
  - Tick fires when the counter reaches TICK_DIV-1, so the first tick comes exactly TICK_DIV cycles after entry.
  - On a tick, remaining_time decrements by 1.
  - Tick with remaining_time==1: remaining_time=0, -> IDLE, timing=0, all_money=0, done=1 for one cycle.
  - Cancel key -> IDLE on the next edge with remaining_time=0 and no done. If cancel and the final tick coincide, cancel wins.
- Tick counter:
  - Runs in ENTRY and TIMING; held at 0 in IDLE.
  - Cleared on every state change and on every accepted key in ENTRY.
- remaining_time never underflows; it is 0 in every state except TIMING.
- Latency: key to all_money update is 1 cycle; start to timing=1 is 1 cycle.

Decomposition:
- Shared package (charger_pkg):
  - State enum IDLE/ENTRY/TIMING.
  - Key code constants KEY_CLEAR=4'hA and KEY_CANCEL=4'hC.
  - Digit-range check function.
- One sub-module, tick_gen:
  - Parameter TICK_DIV.
  - Inputs clk, rst_n, clr; output tick (one-cycle enable).
  - Reused by other timed blocks.

Test Plan (TICK_DIV=4, ENTRY_TIMEOUT=3, defaults otherwise):
- Keys 1, 5, then start -> all_money=15; remaining_time=30 and timing=1 one cycle after start. remaining_time decrements every 4 cycles, reaching 0 at start+120 cycles with done=1 for one cycle, then timing=0 and all_money=0.
- Keys 3, 7, 1, then start -> all_money=20 after key 7 (saturated); key 1 is ignored; remaining_time=40.
- Key 0, then start -> state returns to IDLE; timing stays 0 and done stays 0.
- Key 5, start, then cancel when remaining_time=7 -> next edge shows remaining_time=0 and timing=0; done never asserts. Separately, cancel on the same cycle as the final tick also gives no done.
- Key 4, then no input -> IDLE with all_money=0 exactly 12 cycles after the key. Key 4 then clear -> all_money=0 on the next edge.
- start and key_valid(9) in the same cycle in ENTRY with all_money=2 -> remaining_time=4 and the digit is discarded. Then rst_n=0 for one cycle mid-TIMING -> all outputs 0 on that edge, no done.
